// File: rtl/collision_scheduler.sv
// Frame-rate frog-vs-car collision scanner: snapshots positions on a frame tick,
// runs one shared AABB comparator over all cars (one per clock), then publishes the hit mask.
module collision_scheduler #(
    parameter int TILE_SIZE = 32,
    parameter int NUM_CARS  = 8,
    parameter int LANE0_Y   = 96,
    parameter int LANE1_Y   = 160,
    parameter int LANE2_Y   = 224,
    parameter int LANE3_Y   = 288
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_N,
    input  logic                     i_Enable,
    input  logic                     i_Frame_Start,
    input  logic [9:0]               i_Frog_X,
    input  logic [8:0]               i_Frog_Y,
    input  logic [10*NUM_CARS-1:0]   i_Car_X,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_Has_Collided,
    output logic [NUM_CARS-1:0]      o_Hit_Mask,
    output logic                     o_Missed_Tick,
    output logic [1:0]               o_Dbg_State
);

    localparam int IDX_W = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CARS - 1);
    localparam logic [10:0] TILE_W = 11'(TILE_SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t                  r_State, w_State_Next;
    logic [9:0]              r_Frog_X, w_Frog_X_Next;
    logic [8:0]              r_Frog_Y, w_Frog_Y_Next;
    logic [10*NUM_CARS-1:0]  r_Car_Snap, w_Car_Snap_Next;
    logic [IDX_W-1:0]        r_Idx, w_Idx_Next;
    logic [NUM_CARS-1:0]     r_Work_Mask, w_Work_Mask_Next;
    logic                    r_Busy, w_Busy_Next;
    logic                    r_Done, w_Done_Next;
    logic                    r_Has_Collided, w_Has_Collided_Next;
    logic [NUM_CARS-1:0]     r_Hit_Mask, w_Hit_Mask_Next;
    logic                    r_Missed_Tick, w_Missed_Tick_Next;

    // Shared comparator: car r_Idx from the snapshot against the snapshotted frog.
    // Everything is widened to 11 bits so X up to 1023 + TILE_SIZE cannot wrap.
    logic [9:0]  w_Car_X_Sel;
    logic [1:0]  w_Lane;
    logic [10:0] w_Lane_Y;
    logic [10:0] w_Frog_X_W;
    logic [10:0] w_Frog_Y_W;
    logic [10:0] w_Car_X_W;
    logic        w_Hit_X;
    logic        w_Hit_Y;
    logic        w_Hit;

    assign w_Car_X_Sel = r_Car_Snap[r_Idx*10 +: 10];
    assign w_Lane      = 2'(32'(r_Idx) % 32'd4);
    assign w_Frog_X_W  = {1'b0, r_Frog_X};
    assign w_Frog_Y_W  = {2'b00, r_Frog_Y};
    assign w_Car_X_W   = {1'b0, w_Car_X_Sel};

    always_comb begin
        w_Lane_Y = 11'(LANE0_Y);
        case (w_Lane)
            2'd0:    w_Lane_Y = 11'(LANE0_Y);
            2'd1:    w_Lane_Y = 11'(LANE1_Y);
            2'd2:    w_Lane_Y = 11'(LANE2_Y);
            default: w_Lane_Y = 11'(LANE3_Y);
        endcase
    end

    assign w_Hit_X = (w_Frog_X_W + TILE_W > w_Car_X_W) && (w_Frog_X_W < w_Car_X_W + TILE_W);
    assign w_Hit_Y = (w_Frog_Y_W + TILE_W > w_Lane_Y)  && (w_Frog_Y_W < w_Lane_Y + TILE_W);
    assign w_Hit   = w_Hit_X && w_Hit_Y;

    // Protocol: i_Frame_Start is a single-cycle tick accepted only in IDLE with i_Enable=1;
    // o_Done pulses once when o_Hit_Mask/o_Has_Collided update, ticks while busy raise o_Missed_Tick.
    always_comb begin
        w_State_Next        = r_State;
        w_Frog_X_Next       = r_Frog_X;
        w_Frog_Y_Next       = r_Frog_Y;
        w_Car_Snap_Next     = r_Car_Snap;
        w_Idx_Next          = r_Idx;
        w_Work_Mask_Next    = r_Work_Mask;
        w_Busy_Next         = r_Busy;
        w_Done_Next         = 1'b0;
        w_Has_Collided_Next = r_Has_Collided;
        w_Hit_Mask_Next     = r_Hit_Mask;
        w_Missed_Tick_Next  = i_Frame_Start && (r_State != S_IDLE);

        case (r_State)
            S_IDLE: begin
                if (i_Frame_Start && i_Enable) begin
                    w_Frog_X_Next    = i_Frog_X;
                    w_Frog_Y_Next    = i_Frog_Y;
                    w_Car_Snap_Next  = i_Car_X;
                    w_Work_Mask_Next = '0;
                    w_Idx_Next       = '0;
                    w_Busy_Next      = 1'b1;
                    w_State_Next     = S_SCAN;
                end
            end
            S_SCAN: begin
                if (!i_Enable) begin
                    // Abort: stale results would be misleading, so they are cleared too.
                    w_Busy_Next         = 1'b0;
                    w_Has_Collided_Next = 1'b0;
                    w_Hit_Mask_Next     = '0;
                    w_State_Next        = S_IDLE;
                end else begin
                    w_Work_Mask_Next[r_Idx] = w_Hit;
                    w_Idx_Next              = r_Idx + 1'b1;
                    if (r_Idx == LAST_IDX) begin
                        w_State_Next = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                w_Hit_Mask_Next     = r_Work_Mask;
                w_Has_Collided_Next = |r_Work_Mask;
                w_Done_Next         = 1'b1;
                w_Busy_Next         = 1'b0;
                w_State_Next        = S_IDLE;
            end
            default: begin
                w_Busy_Next  = 1'b0;
                w_State_Next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_State        <= S_IDLE;
            r_Frog_X       <= '0;
            r_Frog_Y       <= '0;
            r_Car_Snap     <= '0;
            r_Idx          <= '0;
            r_Work_Mask    <= '0;
            r_Busy         <= 1'b0;
            r_Done         <= 1'b0;
            r_Has_Collided <= 1'b0;
            r_Hit_Mask     <= '0;
            r_Missed_Tick  <= 1'b0;
        end else begin
            r_State        <= w_State_Next;
            r_Frog_X       <= w_Frog_X_Next;
            r_Frog_Y       <= w_Frog_Y_Next;
            r_Car_Snap     <= w_Car_Snap_Next;
            r_Idx          <= w_Idx_Next;
            r_Work_Mask    <= w_Work_Mask_Next;
            r_Busy         <= w_Busy_Next;
            r_Done         <= w_Done_Next;
            r_Has_Collided <= w_Has_Collided_Next;
            r_Hit_Mask     <= w_Hit_Mask_Next;
            r_Missed_Tick  <= w_Missed_Tick_Next;
        end
    end

    assign o_Busy         = r_Busy;
    assign o_Done         = r_Done;
    assign o_Has_Collided = r_Has_Collided;
    assign o_Hit_Mask     = r_Hit_Mask;
    assign o_Missed_Tick  = r_Missed_Tick;
    assign o_Dbg_State    = r_State;

endmodule
